// File: rtl/session_pkg.sv
// Purpose: shared types and constants for the session scheduler slice.
//   state_t        - scheduler FSM states
//   MSG_W / KEY_W  - datapath message and key widths
//   DEF_*          - default scheduler parameters
package session_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam int MSG_W        = 64;
  localparam int KEY_W        = 8;
  localparam int DEF_N_DRONES = 4;
  localparam int DEF_TIMEOUT  = 200;

endpackage

// File: rtl/session_scheduler_if.sv
// Purpose: bundle between the session scheduler and the key-exchange datapath.
//   dp_start     - one-cycle start pulse          (scheduler -> datapath)
//   dp_rst       - one-cycle abort reset pulse    (scheduler -> datapath)
//   dp_msg       - message of the granted drone   (scheduler -> datapath)
//   dp_done      - completion strobe              (datapath -> scheduler)
//   dp_key       - shared key                     (datapath -> scheduler)
//   dp_decrypted - decrypted message              (datapath -> scheduler)
interface session_scheduler_if;
  import session_pkg::*;

  logic             dp_start;
  logic             dp_rst;
  logic [MSG_W-1:0] dp_msg;
  logic             dp_done;
  logic [KEY_W-1:0] dp_key;
  logic [MSG_W-1:0] dp_decrypted;

  modport master (
    output dp_start, dp_rst, dp_msg,
    input  dp_done, dp_key, dp_decrypted
  );

  modport slave (
    input  dp_start, dp_rst, dp_msg,
    output dp_done, dp_key, dp_decrypted
  );

endinterface

// File: rtl/session_scheduler_rr_arbiter.sv
// Purpose: combinational round-robin arbiter; picks the first set request at
// or after the pointer, wrapping modulo N.
//   req     - request vector
//   pointer - highest-priority index this round (must be < N)
//   grant   - one-hot winner
//   id      - binary index of the winner
//   any     - at least one request is set
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] pointer,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id,
  output logic            any
);

  // Scan N positions starting at the pointer; the first hit wins. The index
  // never exceeds 2N-2, so a single conditional subtract performs the wrap.
  always_comb begin
    int idx;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(pointer) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/session_scheduler.sv
// Purpose: shares one key-exchange datapath between N_DRONES requesters.
// Arbitrates round-robin, launches one session at a time with a timeout and
// returns the result tagged with the drone ID.
//   clk, rst, ena         - clock, synchronous active-high reset, clock enable
//   req                   - per-drone level request
//   msg_flat              - drone i message at bits [64i+63:64i]
//   grant                 - one-hot grant for the session in progress
//   dp                    - datapath bundle (master side)
//   res_valid/id/msg/key  - result strobe and payload
//   res_err               - result is a timeout abort
//   busy                  - scheduler not idle
module session_scheduler
  import session_pkg::*;
#(
  parameter int N_DRONES = DEF_N_DRONES,
  parameter int ID_W     = 2,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TO_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [N_DRONES-1:0]       req,
  input  logic [MSG_W*N_DRONES-1:0] msg_flat,
  output logic [N_DRONES-1:0]       grant,
  session_scheduler_if.master       dp,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [MSG_W-1:0]          res_msg,
  output logic [KEY_W-1:0]          res_key,
  output logic                      res_err,
  output logic                      busy
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [TO_W-1:0] timer;

  logic [N_DRONES-1:0] arb_grant;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;

  rr_arbiter #(
    .N    (N_DRONES),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req),
    .pointer (rr_ptr),
    .grant   (arb_grant),
    .id      (arb_id),
    .any     (arb_any)
  );

  // Session FSM with all outputs registered. Pulse outputs default low each
  // enabled cycle; with ena low everything, pulses included, simply holds.
  // dp_start is raised on the START exit edge so it appears one cycle after
  // grant, in the first WAIT cycle where the timer reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      timer       <= '0;
      grant       <= '0;
      dp.dp_start <= 1'b0;
      dp.dp_rst   <= 1'b0;
      dp.dp_msg   <= '0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_msg     <= '0;
      res_key     <= '0;
      res_err     <= 1'b0;
      busy        <= 1'b0;
    end else if (ena) begin
      dp.dp_start <= 1'b0;
      dp.dp_rst   <= 1'b0;
      res_valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_ARB;
            busy  <= 1'b1;
          end
        end
        S_ARB: begin
          // Requests may vanish between IDLE and ARB; back off without a grant.
          if (arb_any) begin
            grant     <= arb_grant;
            cur_id    <= arb_id;
            dp.dp_msg <= msg_flat[arb_id*MSG_W +: MSG_W];
            state     <= S_START;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_START: begin
          dp.dp_start <= 1'b1;
          timer       <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // Completion is checked first so it beats a coinciding timeout.
          if (dp.dp_done) begin
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_id    <= cur_id;
            res_msg   <= dp.dp_decrypted;
            res_key   <= dp.dp_key;
            state     <= S_DONE;
          end else if (timer == TO_W'(TIMEOUT - 1)) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_id    <= cur_id;
            res_msg   <= '0;
            res_key   <= '0;
            dp.dp_rst <= 1'b1;
            state     <= S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          // Winner drops to lowest priority for the next round.
          rr_ptr <= (cur_id == ID_W'(N_DRONES - 1)) ? '0 : cur_id + 1'b1;
          grant  <= '0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/session_scheduler.md
Name: session_scheduler

Overview:
- Shares one command-centre/drone key-exchange datapath between N_DRONES requesters.
- Picks a requester round-robin and drives its 64-bit message into the datapath.
- Pulses the datapath start, waits for completion with a timeout, and returns the decrypted message and key tagged with the drone ID.
- Sits directly above the key-exchange world instance; one session runs at a time.

Parameters:
- N_DRONES, 4, number of requesting drones (2..16).
- ID_W, 2, width of drone ID; must equal clog2(N_DRONES).
- TIMEOUT, 200, max cycles in WAIT before abort (1..2^TO_W-1).
- TO_W, 8, timeout counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  clock enable; when low all state, counters and outputs hold.
- req  in  N_DRONES  per-drone session request, level, held until grant.
- msg_flat  in  64*N_DRONES  drone i message at bits [64i+63:64i].
- grant  out  N_DRONES  one-hot; high from ARB exit until DONE/ERR exit.
- dp_start  out  1  one-cycle start pulse to datapath.
- dp_rst  out  1  one-cycle datapath reset pulse after abort.
- dp_msg  out  64  message of granted drone, registered, stable for the whole session.
- dp_done  in  1  datapath completion (decrypted and key valid this cycle).
- dp_key  in  8  shared key from datapath.
- dp_decrypted  in  64  decrypted message from datapath.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  ID_W  drone ID of result.
- res_msg  out  64  decrypted message.
- res_key  out  8  key.
- res_err  out  1  qualifies res_valid; 1 = timeout, res_msg/res_key = 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at clk edge, regardless of ena): state IDLE, rr pointer 0, timer 0. All outputs 0: grant, dp_start, dp_rst, dp_msg, res_*, busy.
- All transitions below occur only on cycles with ena=1.
- IDLE: if any req bit is set, go to ARB. res_valid and dp_rst are 0.
- ARB (1 cycle):
  - Grant the first set req bit at or after the rr pointer, wrapping modulo N_DRONES.
  - Latch the winner's message into dp_msg and its ID; set grant one-hot.
  - If req went to all-zero in this cycle, return to IDLE with no grant.
- START (1 cycle): dp_start=1, timer cleared to 0, go to WAIT.
- WAIT:
  - Timer increments each enabled cycle.
  - dp_done=1: capture dp_decrypted and dp_key, go to DONE.
  - Otherwise, timer==TIMEOUT-1: go to ERR.
  - If dp_done and the timeout coincide, dp_done wins.
  - dp_done in any state other than WAIT is ignored.
- DONE (1 cycle):
  - res_valid=1, res_err=0, res_id=latched ID, res_msg/res_key=captured values.
  - rr pointer = granted ID+1 (mod N_DRONES); grant cleared; go to IDLE.
- ERR (1 cycle):
  - res_valid=1, res_err=1, res_msg=0, res_key=0, dp_rst=1.
  - rr pointer advances as in DONE; go to IDLE.
- Latency:
  - Req rising in IDLE → grant in 2 cycles (IDLE→ARB edge, then ARB edge).
  - dp_start follows the grant by 1 cycle.
  - res_valid comes 1 cycle after dp_done.
- Back-to-back sessions: minimum 1 IDLE cycle between sessions; IDLE→ARB is taken the cycle after DONE/ERR.
- Requester dropping req mid-session: ignored; the session completes and result delivery is unaffected.
- Requester holding req after its result: re-arbitrated; other pending requesters take precedence through the pointer (fairness bound: N_DRONES sessions).
- res_id/res_msg/res_key hold their last value between strobes; res_err clears with the next res_valid.
- Synchronous reset during any state aborts the session without a dp_rst pulse; the datapath shares rst.

Decomposition:
- Package session_pkg:
  - state enum {S_IDLE, S_ARB, S_START, S_WAIT, S_DONE, S_ERR}
  - MSG_W=64, KEY_W=8
  - default N_DRONES/TIMEOUT constants
- Sub-module rr_arbiter: combinational priority rotate.
  - Inputs: req, pointer. Outputs: one-hot grant, ID, any.
  - Reusable by other shared-resource blocks.
- FSM, timer and result registers stay in session_scheduler.

Test Plan:
- Single request: req=0001, msg0=64'h0123_4567_89AB_CDEF, dp_done after 10 cycles with decrypted=same, key=8'h5A → grant=0001, one dp_start, res_valid with res_id=0, res_msg=0123_4567_89AB_CDEF, res_key=5A, res_err=0.
- Round-robin: req=1111 held, dp_done 3 cycles after each start → grant order 0,1,2,3,0; the 5th session has res_id=0.
- Timeout: TIMEOUT=20, req=0100, dp_done never → res_valid with res_err=1 and res_id=2 exactly 20 cycles after dp_start; dp_rst pulses once.
- Done at timeout boundary: dp_done asserted in the cycle timer==TIMEOUT-1 → res_err=0, result captured.
- ena gating: ena=0 for 5 cycles in WAIT → timer frozen; the timeout is extended by 5 cycles and outputs are unchanged.
- Reset mid-WAIT: rst=1 one cycle → next cycle state IDLE, grant=0, busy=0, no res_valid; pending req re-granted to ID 0 first.
